// File: rtl/fft_bf_scheduler.sv
// Address/strobe sequencer that drives one radix-2 DIF butterfly over an in-place N-point transform.
// Stages are separated by a drain barrier so every result of a stage is written before the next stage reads.
module fft_bf_scheduler #(
   parameter int N      = 16,
   parameter int LOG_N  = 4,
   parameter int MWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [LOG_N-1:0]  rd_addr_a,
   output logic [LOG_N-1:0]  rd_addr_b,
   output logic [LOG_N-2:0]  tw_addr,
   output logic              bf_x_nd,
   output logic [MWIDTH-1:0] bf_m_in,
   input  logic              bf_y_nd,
   input  logic [MWIDTH-1:0] bf_m_out,
   output logic              wr_en,
   output logic [LOG_N-1:0]  wr_addr_a,
   output logic [LOG_N-1:0]  wr_addr_b,
   output logic              error,
   output logic [1:0]        state_dbg
);

   localparam int KW = LOG_N - 1;
   localparam int SW = $clog2(LOG_N);
   localparam logic [KW-1:0]    K_LAST = KW'(N/2 - 1);
   localparam logic [SW-1:0]    S_LAST = SW'(LOG_N - 1);
   localparam logic [LOG_N-1:0] HALF   = LOG_N'(N/2);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t             state_q;
   logic [SW-1:0]      s_q;
   logic [KW-1:0]      k_q;
   logic [LOG_N-1:0]   cnt_q, cnt_d;
   logic               busy_q, done_q, rd_en_q, x_nd_q, err_q;
   logic [LOG_N-1:0]   rd_a_q, rd_b_q;
   logic [KW-1:0]      tw_q;
   logic [MWIDTH-1:0]  m_in_q;

   logic [KW-1:0]      iss_k;
   logic [SW-1:0]      iss_s, p;
   logic [LOG_N-1:0]   kk, hh, lo, nx_a, nx_b;
   logic [KW-1:0]      nx_tw;
   logic               err_set, drain_ok;

   // Index of the butterfly that the next rd_en edge will present.
   always_comb begin
      iss_k = '0;
      iss_s = '0;
      case (state_q)
         S_ISSUE: begin
            iss_k = k_q + KW'(1);
            iss_s = s_q;
         end
         S_DRAIN: iss_s = s_q + SW'(1);
         default: ;
      endcase
      p     = S_LAST - iss_s;
      kk    = {1'b0, iss_k};
      hh    = LOG_N'(1) << p;
      lo    = hh - LOG_N'(1);
      nx_a  = (((kk >> p) << p) << 1) | (kk & lo);
      nx_b  = nx_a | hh;
      nx_tw = KW'((kk & lo) << iss_s);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (x_nd_q && !bf_y_nd && cnt_q != HALF)
         cnt_d = cnt_q + LOG_N'(1);
      else if (bf_y_nd && !x_nd_q && cnt_q != '0)
         cnt_d = cnt_q - LOG_N'(1);
      err_set  = bf_y_nd && ((state_q == S_IDLE) || (cnt_q == '0 && !x_nd_q));
      // Looking at the post-update count lets the next stage start the cycle after the last write.
      drain_ok = (cnt_d == '0) && !x_nd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         s_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
         rd_a_q  <= '0;
         rd_b_q  <= '0;
         tw_q    <= '0;
         x_nd_q  <= 1'b0;
         m_in_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         x_nd_q <= rd_en_q;
         m_in_q <= {rd_a_q, rd_b_q};
         cnt_q  <= cnt_d;
         err_q  <= err_q | err_set;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start) begin
               state_q <= S_ISSUE;
               busy_q  <= 1'b1;
               rd_en_q <= 1'b1;
               s_q     <= '0;
               k_q     <= '0;
               rd_a_q  <= nx_a;
               rd_b_q  <= nx_b;
               tw_q    <= nx_tw;
            end
            S_ISSUE: if (k_q == K_LAST) begin
               k_q     <= '0;
               rd_en_q <= 1'b0;
               state_q <= S_DRAIN;
            end else begin
               k_q    <= iss_k;
               rd_a_q <= nx_a;
               rd_b_q <= nx_b;
               tw_q   <= nx_tw;
            end
            S_DRAIN: if (drain_ok) begin
               if (s_q == S_LAST) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= S_ISSUE;
                  s_q     <= iss_s;
                  rd_en_q <= 1'b1;
                  rd_a_q  <= nx_a;
                  rd_b_q  <= nx_b;
                  tw_q    <= nx_tw;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_en     = rd_en_q;
   assign rd_addr_a = rd_a_q;
   assign rd_addr_b = rd_b_q;
   assign tw_addr   = tw_q;
   assign bf_x_nd   = x_nd_q;
   assign bf_m_in   = m_in_q;
   assign error     = err_q;
   assign state_dbg = state_q;
   assign wr_en     = bf_y_nd;
   assign wr_addr_a = bf_m_out[MWIDTH-1:LOG_N];
   assign wr_addr_b = bf_m_out[LOG_N-1:0];

endmodule

// File: tb/tb_fft_bf_scheduler.sv
// Bench for fft_bf_scheduler at N=8: a latency-configurable butterfly model, a DIF address reference
// built from nested group/pair loops, and directed plus randomized transform sequences.
module tb_fft_bf_scheduler;

   localparam int N     = 8;
   localparam int LOG_N = 3;
   localparam int MW    = 2 * LOG_N;
   localparam int HALF  = N / 2;
   localparam int TOTAL = LOG_N * HALF;
   localparam int W     = 3 * LOG_N - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done, rd_en, bf_x_nd, bf_y_nd, wr_en, error;
   logic [LOG_N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [LOG_N-2:0] tw_addr;
   logic [MW-1:0]    bf_m_in, bf_m_out;
   logic [1:0]       state_dbg;

   logic          bfm_y_nd = 1'b0, man_y_nd = 1'b0;
   logic [MW-1:0] bfm_m = '0, man_m = '0;
   assign bf_y_nd  = bfm_y_nd | man_y_nd;
   assign bf_m_out = man_y_nd ? man_m : bfm_m;

   fft_bf_scheduler #(.N(N), .LOG_N(LOG_N), .MWIDTH(MW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
      .bf_x_nd(bf_x_nd), .bf_m_in(bf_m_in), .bf_y_nd(bf_y_nd), .bf_m_out(bf_m_out),
      .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .error(error),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0]    exp_q[$];
   logic [2*LOG_N-1:0] tag_q[$];
   int  n_issue = 0, n_wr = 0, last_wr_cyc = -100, exp_first_cyc = 0, t0 = 0;
   bit  mon_on = 1'b0;
   logic prev_rd = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // ---------------- butterfly model ----------------
   typedef struct {int due; logic [MW-1:0] m;} bf_item_t;
   bf_item_t bfq[$];
   int lat = 5;

   always @(negedge clk)
      if (bf_x_nd === 1'b1) bfq.push_back('{due: cyc + lat, m: bf_m_in});

   always @(posedge clk) begin
      #1;
      if (bfq.size() > 0 && bfq[0].due <= cyc) begin
         bfm_m    = bfq[0].m;
         bfm_y_nd = 1'b1;
         bfq.delete(0);
      end else begin
         bfm_y_nd = 1'b0;
      end
   end

   // ---------------- reference: DIF pair enumeration ----------------
   task automatic prep_model();
      int h;
      logic [LOG_N-1:0] a, b;
      logic [LOG_N-2:0] tw;
      exp_q.delete();
      tag_q.delete();
      n_issue = 0;
      n_wr = 0;
      last_wr_cyc = -100;
      for (int s = 0; s < LOG_N; s++) begin
         h = N >> (s + 1);
         for (int j0 = 0; j0 < N; j0 += 2 * h)
            for (int i = 0; i < h; i++) begin
               a  = LOG_N'(j0 + i);
               b  = LOG_N'(j0 + i + h);
               tw = (LOG_N-1)'(i << s);
               exp_q.push_back({a, b, tw});
            end
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [2*LOG_N-1:0] t;
      if (mon_on) begin
         chk("x_nd_follows_rd", bf_x_nd, prev_rd);
         if (rd_en === 1'b1) begin
            chk("busy_on_issue", busy, 1);
            if (n_issue == 0)
               chk("first_rd_cycle", cyc, exp_first_cyc);
            else if (n_issue % HALF == 0) begin
               chk("barrier_writes", n_wr, n_issue);
               chk("barrier_cycle", cyc, last_wr_cyc + 1);
            end
            if (exp_q.size() == 0)
               chk("rd_unexpected", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("rd_addr_a", rd_addr_a, e[W-1 -: LOG_N]);
               chk("rd_addr_b", rd_addr_b, e[LOG_N+LOG_N-2 -: LOG_N]);
               chk("tw_addr", tw_addr, e[LOG_N-2:0]);
               tag_q.push_back(e[W-1 -: 2*LOG_N]);
            end
            n_issue++;
         end
         if (bf_x_nd === 1'b1) begin
            if (tag_q.size() == 0)
               chk("x_nd_unexpected", 1, 0);
            else begin
               t = tag_q.pop_front();
               chk("bf_m_in", bf_m_in, t);
            end
         end
         if (bfm_y_nd) begin
            n_wr++;
            last_wr_cyc = cyc;
            chk("wr_en", wr_en, 1);
            chk("wr_addr_a", wr_addr_a, bfm_m[MW-1:LOG_N]);
            chk("wr_addr_b", wr_addr_b, bfm_m[LOG_N-1:0]);
         end
         if (done === 1'b1) begin
            chk("done_after_drain", cyc, last_wr_cyc + 1);
            chk("busy_at_done", busy, 0);
            chk("writes_at_done", n_wr, TOTAL);
         end
      end
      prev_rd = rd_en;
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic start_xform(input bit hold);
      prep_model();
      exp_first_cyc = cyc + 1;
      t0 = cyc;
      start = 1'b1;
      mon_on = 1'b1;
      step();
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_done(output int dc);
      int guard = 0;
      while (done !== 1'b1 && guard < 300) begin
         step();
         guard++;
      end
      chk("done_timeout", done, 1);
      chk("issue_count", n_issue, TOTAL);
      chk("model_drained", exp_q.size(), 0);
      dc = cyc;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int dc, seen, guard, gap;
      bit hold;
      logic [MW-1:0] m;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_x_nd", bf_x_nd, 0);
      chk("rst_error", error, 0);
      chk("rst_rd_addr_a", rd_addr_a, 0);
      chk("rst_rd_addr_b", rd_addr_b, 0);
      chk("rst_tw_addr", tw_addr, 0);
      chk("rst_m_in", bf_m_in, 0);
      rst_n = 1'b1;
      step();

      // latency 5: fixed timeline, done 31 cycles after start
      lat = 5;
      start_xform(1'b0);
      chk("busy_cycle1", busy, 1);
      chk("rd_en_cycle1", rd_en, 1);
      wait_done(dc);
      chk("done_cycle_lat5", dc - t0, 31);
      chk("error_clean", error, 0);

      // start during DONE is ignored
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("idle_after_done_busy", busy, 0);
         chk("idle_after_done_rd", rd_en, 0);
         step();
      end

      // start held high: exactly one transform, next one only once IDLE samples it
      lat = 3;
      start_xform(1'b1);
      wait_done(dc);
      step();
      chk("held_idle_busy", busy, 0);
      prep_model();
      exp_first_cyc = cyc + 1;
      step();
      start = 1'b0;
      chk("held_restart_busy", busy, 1);
      wait_done(dc);
      step();

      // randomized latencies, gaps and start holding
      for (int r = 0; r < 6; r++) begin
         lat  = $urandom_range(1, 8);
         gap  = $urandom_range(0, 3);
         hold = 1'($urandom_range(0, 1));
         repeat (gap) step();
         start_xform(hold);
         wait_done(dc);
         start = 1'b0;
         chk("error_clean_rand", error, 0);
         step();
      end
      mon_on = 1'b0;

      // tag routing and spurious result in IDLE
      man_m = 6'b010_110;
      man_y_nd = 1'b1;
      #1;
      chk("tag_wr_en", wr_en, 1);
      chk("tag_wr_addr_a", wr_addr_a, 2);
      chk("tag_wr_addr_b", wr_addr_b, 6);
      step();
      man_y_nd = 1'b0;
      chk("spurious_error", error, 1);
      for (int i = 0; i < 3; i++) begin
         m = MW'($urandom_range(0, (1 << MW) - 1));
         man_m = m;
         man_y_nd = 1'b1;
         #1;
         chk("rand_wr_addr_a", wr_addr_a, m >> LOG_N);
         chk("rand_wr_addr_b", wr_addr_b, m & ((1 << LOG_N) - 1));
         step();
         man_y_nd = 1'b0;
         step();
      end

      // sticky error does not stop the FSM
      lat = $urandom_range(1, 6);
      start_xform(1'b0);
      wait_done(dc);
      chk("error_sticky", error, 1);
      step();
      mon_on = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("error_cleared_by_reset", error, 0);
      step();
      rst_n = 1'b1;
      step();

      // reset during stage 1 ISSUE, with results still in flight
      lat = 6;
      start_xform(1'b0);
      guard = 0;
      while (n_issue < HALF + 3 && guard < 200) begin
         step();
         guard++;
      end
      chk("reach_stage1", n_issue, HALF + 3);
      chk("stage1_rd_en", rd_en, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_rd_en", rd_en, 0);
      chk("midrst_x_nd", bf_x_nd, 0);
      mon_on = 1'b0;
      step();
      rst_n = 1'b1;
      seen = 0;
      guard = 0;
      while ((bfq.size() > 0 || bfm_y_nd) && guard < 50) begin
         step();
         if (bfm_y_nd) begin
            seen++;
            chk("late_wr_en", wr_en, 1);
         end
         guard++;
      end
      chk("late_results_seen", seen > 0, 1);
      chk("late_error", error, 1);
      step();

      // restart from stage 0, k=0 after the aborted transform
      lat = 4;
      start_xform(1'b0);
      chk("restart_rd_addr_a", rd_addr_a, 0);
      chk("restart_rd_addr_b", rd_addr_b, 4);
      wait_done(dc);
      chk("restart_error_kept", error, 1);
      step();
      mon_on = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
